shift_mult_n: RTL

Parametrised sequential shift-and-add multiplier, successor to the fixed 8-bit mult8. Computes a WIDTH x WIDTH -> 2*WIDTH product, one multiplier bit per clock, in unsigned or two's-complement signed mode, selected per operation. Adds a start/busy/done handshake so an arithmetic datapath controller can issue back-to-back operations.

---
 rtl/shift_mult_n_pkg.sv | 37 +++
 rtl/shift_mult_n.sv | 137 +++++++++++++
 2 files changed

// File: rtl/shift_mult_n_pkg.sv
// ---------------------------------------------------------------------------
// shift_mult_pkg
// Shared definitions for the shift-and-add multiplier family:
//   state_t        - controller states (IDLE, CALC, FIN)
//   MODE_UNSIGNED  - signed_mode encoding for unsigned operands
//   MODE_SIGNED    - signed_mode encoding for two's-complement operands
//   MAG_W          - width of the generic magnitude helper (largest legal WIDTH)
//   mag_f()        - two's-complement magnitude of a sign-extended MAG_W value
// ---------------------------------------------------------------------------
package shift_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  localparam int MAG_W = 32;

  // Callers sign-extend (signed mode) or zero-extend (unsigned mode) their
  // operand to MAG_W bits first, so one function serves every WIDTH. The most
  // negative WIDTH-bit value becomes +2^(WIDTH-1), which still fits after the
  // caller truncates back to WIDTH bits as an unsigned magnitude.
  function automatic logic [MAG_W-1:0] mag_f(input logic [MAG_W-1:0] v);
    logic [MAG_W-1:0] r;
    if (v[MAG_W-1]) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_mult_n.sv
// ---------------------------------------------------------------------------
// shift_mult_n
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one
// multiplier bit per clock. Signed operation multiplies magnitudes and
// applies the sign at the end.
//
// Ports:
//   clk          in   rising-edge clock
//   sig          in   synchronous active-high reset
//   start        in   operation request, sampled only while idle
//   signed_mode  in   1 = two's complement operands/result, 0 = unsigned
//   ina          in   WIDTH-bit multiplicand
//   inb          in   WIDTH-bit multiplier
//   busy         out  high while an operation is in progress
//   done         out  one-cycle pulse when out is updated
//   out          out  2*WIDTH-bit product, held until the next done
//
// Timing: start sampled at edge k -> WIDTH iterations on edges k+1..k+WIDTH
// -> result and done on edge k+WIDTH+1.
// ---------------------------------------------------------------------------
module shift_mult_n
  import shift_mult_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               sig,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]   inb,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  state_t               r_state;
  logic                 r_mode;
  logic                 r_sign_x;   // operand sign bits differ
  logic [2*WIDTH-1:0]   r_mcand;    // multiplicand, pre-shifted by cnt
  logic [WIDTH-1:0]     r_mplier;   // multiplier, consumed LSB first
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;

  logic [MAG_W-1:0]     w_a_ext;
  logic [MAG_W-1:0]     w_b_ext;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_neg;

  // Extend operands to the helper width according to the requested mode.
  always_comb begin
    w_a_ext = MAG_W'(ina);
    w_b_ext = MAG_W'(inb);
    if (signed_mode == MODE_SIGNED) begin
      w_a_ext = MAG_W'($signed(ina));
      w_b_ext = MAG_W'($signed(inb));
    end else begin
      w_a_ext = MAG_W'(ina);
      w_b_ext = MAG_W'(inb);
    end
  end

  assign w_a_mag = WIDTH'(mag_f(w_a_ext));
  assign w_b_mag = WIDTH'(mag_f(w_b_ext));

  // A zero product is never negated, so negative zero cannot appear.
  assign w_neg = (r_mode == MODE_SIGNED) && r_sign_x && (r_acc != '0);

  // Controller and datapath: IDLE -> CALC (WIDTH cycles) -> FIN -> IDLE.
  always_ff @(posedge clk) begin
    if (sig) begin
      r_state  <= IDLE;
      r_mode   <= MODE_UNSIGNED;
      r_sign_x <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode   <= signed_mode;
            r_sign_x <= ina[WIDTH-1] ^ inb[WIDTH-1];
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= CALC;
          end else begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        CALC: begin
          // Shifting the multiplicand each cycle is equivalent to adding
          // multiplicand << cnt; the 2*WIDTH accumulator cannot overflow.
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end else begin
            r_acc <= r_acc;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= FIN;
          end else begin
            r_state <= CALC;
          end
        end
        FIN: begin
          if (w_neg) begin
            out <= (~r_acc) + {{(2*WIDTH-1){1'b0}}, 1'b1};
          end else begin
            out <= r_acc;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
